// File: rtl/booth_control.sv
// rtl/booth_control.sv - Booth multiplier control FSM for a 7-bit A/B/P datapath
module booth_control (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       b_lsb,
    input  logic       x,
    input  logic       flag,
    output logic       af1,
    output logic       af0,
    output logic       bf1,
    output logic       bf0,
    output logic       pf1,
    output logic       pf0,
    output logic       m,
    output logic       ci,
    output logic       e,
    output logic       cnt_clr,
    output logic       busy,
    output logic       done,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EXAM  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t     state_q;
    logic [1:0] af_q;
    logic [1:0] bf_q;
    logic [1:0] pf_q;
    logic       e_q;
    logic       cnt_clr_q;
    logic       busy_q;
    logic       done_q;

    // EXAM with the counter not yet at 7 is the only place the Booth pair is decoded
    logic       exam_active;
    logic       booth_op;
    logic [1:0] pf_out;

    assign exam_active = (state_q == EXAM) && !flag;
    // {b_lsb,x} = 10 subtracts, 01 adds; 00/11 leave P alone
    assign booth_op    = exam_active && (b_lsb ^ x);

    // Mealy overlay: the add/subtract request replaces the registered P code in EXAM
    always_comb begin
        pf_out = pf_q;
        if (booth_op) begin
            pf_out = 2'b01;
        end
    end

    // Next state and registered Moore outputs for the state being entered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            af_q      <= 2'b00;
            bf_q      <= 2'b00;
            pf_q      <= 2'b00;
            e_q       <= 1'b0;
            cnt_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            af_q      <= 2'b00;
            bf_q      <= 2'b00;
            pf_q      <= 2'b00;
            e_q       <= 1'b0;
            cnt_clr_q <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= LOAD;
                        af_q      <= 2'b01;
                        bf_q      <= 2'b01;
                        pf_q      <= 2'b10;
                        cnt_clr_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    state_q <= EXAM;
                end
                EXAM: begin
                    if (flag) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= SHIFT;
                        pf_q    <= 2'b11;
                        bf_q    <= 2'b10;
                        e_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    state_q <= EXAM;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign af1     = af_q[1];
    assign af0     = af_q[0];
    assign bf1     = bf_q[1];
    assign bf0     = bf_q[0];
    assign pf1     = pf_out[1];
    assign pf0     = pf_out[0];
    assign m       = booth_op && b_lsb;
    assign ci      = booth_op && b_lsb;
    assign e       = e_q;
    assign cnt_clr = cnt_clr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign state   = state_q;

endmodule

// File: tb/tb_booth_control.sv
// tb/tb_booth_control.sv - directed bench for booth_control with a Booth datapath model
module tb_booth_control;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       b_lsb;
    logic       x;
    logic       flag;
    logic       af1, af0, bf1, bf0, pf1, pf0, m, ci, e, cnt_clr, busy, done;
    logic [2:0] state;

    booth_control dut (
        .clock   (clk),
        .reset   (rst),
        .start   (start),
        .b_lsb   (b_lsb),
        .x       (x),
        .flag    (flag),
        .af1     (af1),
        .af0     (af0),
        .bf1     (bf1),
        .bf0     (bf0),
        .pf1     (pf1),
        .pf0     (pf0),
        .m       (m),
        .ci      (ci),
        .e       (e),
        .cnt_clr (cnt_clr),
        .busy    (busy),
        .done    (done),
        .state   (state)
    );

    initial begin
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    // Datapath model: A, B, P registers, x bit and iteration counter
    logic [6:0] a_value = 7'b1111000;
    logic [6:0] b_value = 7'b1111011;
    logic [6:0] a_r = '0;
    logic [6:0] b_r = '0;
    logic [6:0] p_r = '0;
    logic       x_r = 1'b0;
    logic [2:0] cnt_r = '0;
    logic       force_en = 1'b0;
    logic       f_b = 1'b0;
    logic       f_x = 1'b0;
    logic [6:0] sum_diff;

    assign sum_diff = p_r + (a_r ^ {7{m}}) + {6'd0, ci};
    assign b_lsb    = force_en ? f_b : b_r[0];
    assign x        = force_en ? f_x : x_r;
    assign flag     = (cnt_r == 3'd7);

    always @(posedge clk) begin
        if (cnt_clr) cnt_r <= '0;
        else if (e)  cnt_r <= cnt_r + 3'd1;
        if ({af1, af0} == 2'b01) a_r <= a_value;
        case ({bf1, bf0})
            2'b01:   b_r <= b_value;
            2'b10:   b_r <= {p_r[0], b_r[6:1]};
            default: b_r <= b_r;
        endcase
        if (cnt_clr)                  x_r <= 1'b0;
        else if ({bf1, bf0} == 2'b10) x_r <= b_r[0];
        case ({pf1, pf0})
            2'b01:   p_r <= sum_diff;
            2'b10:   p_r <= '0;
            2'b11:   p_r <= {p_r[6], p_r[6:1]};
            default: p_r <= p_r;
        endcase
    end

    logic [11:0] outs;
    assign outs = {af1, af0, bf1, bf0, pf1, pf0, m, ci, e, cnt_clr, busy, done};

    int          n_chk = 0;
    int          n_err = 0;
    int          e_n, clr_n, done_n, done_edge, mc_viol;
    logic [2:0]  state_at [0:31];
    logic        busy_at  [0:31];
    logic [11:0] load_vec;
    logic [13:0] exp_q [$];
    logic [13:0] exp_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Edge k is counted with the start-sampling edge as 1; samples taken 1 time unit after each edge
    task automatic run(input int first, input int last, input int pulse_edge, input bit hold);
        if (first == 1) begin
            e_n = 0; clr_n = 0; done_n = 0; done_edge = -1;
            start = 1'b1;
        end
        for (int k = first; k <= last; k++) begin
            @(posedge clk); #1;
            start = hold || (k == pulse_edge);
            state_at[k] = state;
            busy_at[k]  = busy;
            if (k == 1) load_vec = outs;
            if (e) e_n++;
            if (cnt_clr) clr_n++;
            if (({pf1, pf0} != 2'b01) && (m || ci)) mc_viol++;
            if (done) begin
                done_n++;
                if (done_edge < 0) done_edge = k;
                if (exp_q.size() > 0) begin
                    exp_v = exp_q.pop_front();
                    chk("result", {18'd0, p_r, b_r}, {18'd0, exp_v});
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        mc_viol = 0;
        // Reset with the clock stopped
        #1 rst = 1'b1;
        #1;
        chk("rst_noclk_state", {29'd0, state}, 32'd0);
        chk("rst_noclk_outs", {20'd0, outs}, 32'd0);
        clk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Normal run: -8 * -5
        exp_q.push_back(14'd40);
        run(1, 20, -1, 1'b0);
        chk("load_outs", {20'd0, load_vec}, {20'd0, 12'b01_01_10_00_0_1_1_0});
        chk("load_state", {29'd0, state_at[1]}, 32'd1);
        chk("e_pulses", e_n, 7);
        chk("clr_pulses", clr_n, 1);
        chk("done_edge", done_edge, 17);
        chk("done_count", done_n, 1);
        chk("busy_at_done", {31'd0, busy_at[17]}, 32'd1);
        chk("busy_after_done", {31'd0, busy_at[18]}, 32'd0);
        chk("idle_after_done", {29'd0, state_at[20]}, 32'd0);

        // Start pulsed while in SHIFT of iteration 3 is ignored
        exp_q.push_back(14'd40);
        run(1, 20, 7, 1'b0);
        chk("pulse_shift3_state", {29'd0, state_at[7]}, 32'd3);
        chk("pulse_no_restart", {29'd0, state_at[8]}, 32'd2);
        chk("pulse_done_edge", done_edge, 17);
        chk("pulse_done_count", done_n, 1);
        chk("pulse_clr_pulses", clr_n, 1);

        // Start held through DONE begins a new run from IDLE
        exp_q.push_back(14'd40);
        run(1, 19, -1, 1'b1);
        chk("hold_done_edge", done_edge, 17);
        chk("hold_idle", {29'd0, state_at[18]}, 32'd0);
        chk("hold_reload", {29'd0, state_at[19]}, 32'd1);
        apply_reset();

        // Forced Booth pair decode in the first EXAM
        run(1, 2, -1, 1'b0);
        chk("exam_state", {29'd0, state_at[2]}, 32'd2);
        force_en = 1'b1;
        f_b = 1'b1; f_x = 1'b0; #1;
        chk("exam_10_pfmci", {28'd0, pf1, pf0, m, ci}, 32'b0111);
        f_b = 1'b0; f_x = 1'b1; #1;
        chk("exam_01_pfmci", {28'd0, pf1, pf0, m, ci}, 32'b0100);
        f_b = 1'b1; f_x = 1'b1; #1;
        chk("exam_11_pfmci", {28'd0, pf1, pf0, m, ci}, 32'b0000);
        f_b = 1'b0; f_x = 1'b0; #1;
        chk("exam_00_pfmci", {28'd0, pf1, pf0, m, ci}, 32'b0000);
        force_en = 1'b0;
        run(3, 20, -1, 1'b0);
        chk("forced_done_edge", done_edge, 17);

        // Reset during the 4th SHIFT aborts the run
        exp_q.push_back(14'd40);
        run(1, 9, -1, 1'b0);
        chk("shift4_state", {29'd0, state_at[9]}, 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("midrun_rst_state", {29'd0, state}, 32'd0);
        chk("midrun_rst_outs", {20'd0, outs}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        done_n = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done) done_n++;
            if (state != 3'd0) done_n += 100;
        end
        chk("abort_no_done_idle", done_n, 0);

        exp_q.push_back(14'd40);
        run(1, 20, -1, 1'b0);
        chk("post_rst_done_edge", done_edge, 17);
        chk("post_rst_e_pulses", e_n, 7);
        chk("sb_drained", exp_q.size(), 0);
        chk("m_ci_only_with_add", mc_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
